down_timer: RTL
===============

DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and load-value width in bits.
REQ-002 SHALL have parameter DIV, default 1, clocks per count tick (legal range 1..256).
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load  input  1  capture in into reload register (and count when not running).
REQ-006 SHALL have port in  input  WIDTH  load value.
REQ-007 SHALL have port start  input  1  request countdown.
REQ-008 SHALL have port stop  input  1  abort countdown.
REQ-009 SHALL have port auto_reload  input  1  periodic mode select, sampled at each expiry tick.
REQ-010 SHALL have port count  output  WIDTH  current count value (registered).
REQ-011 SHALL have port running  output  1  high while state RUN.
REQ-012 SHALL have port expired  output  1  high while state EXPIRED.
REQ-013 SHALL have port done  output  1  single-cycle registered pulse on each expiry.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, EXPIRED; all transitions on rising clock edge.
REQ-015 SHALL apply priority per cycle: reset > stop > start > load, with the exceptions given in REQ-020.
REQ-016 SHALL, on load in any state, write in to reload_reg; count also takes in only when state is not RUN.
REQ-017 SHALL, on start in IDLE/EXPIRED with effective count != 0, enter RUN and clear prescaler; effective count = in if load is asserted the same cycle, else count.
REQ-018 SHALL, on start with effective count == 0, enter EXPIRED and pulse done the next cycle.
REQ-019 SHALL ignore start while in RUN (no restart, no prescaler clear).
REQ-020 SHALL, on stop in RUN, enter IDLE, hold count, clear prescaler, suppress any same-cycle tick/done; stop outside RUN is a no-op, and start/load the same cycle are still honoured as in IDLE.
REQ-021 SHALL generate a tick every DIV clocks in RUN; prescaler counts 0..DIV-1 and wraps; tick when prescaler == DIV-1.
REQ-022 SHALL decrement count by 1 on each tick when count > 1.
REQ-023 SHALL, on a tick with count == 1: pulse done next cycle; if auto_reload and reload_reg != 0, load count from reload_reg and stay RUN, else set count 0 and enter EXPIRED.
REQ-024 SHALL give latency: start accepted at edge E0 with count N -> count reaches 0/reloads at edge E0+N*DIV; done high during the cycle following that edge.
REQ-025 SHALL keep count arithmetic WIDTH bits, never underflow below 0, never wrap to all-ones.
REQ-026 SHALL drive running/expired as direct decodes of the state register.

Reset
REQ-027 SHALL, on reset, set state IDLE, count 0, reload_reg 0, prescaler 0, done 0, running 0, expired 0.
REQ-028 SHALL let reset mid-countdown abort immediately with no done pulse, overriding all other inputs.

Structure
REQ-029 SHALL place state enum (IDLE/RUN/EXPIRED) and default WIDTH/DIV constants in package down_timer_pkg.
REQ-030 SHALL implement the prescaler as sub-module tick_gen (inputs clock, reset, enable, clear; output tick).
REQ-031 SHALL let tick_gen with DIV=1 assert tick every enabled cycle, with no prescaler register.

Verification
REQ-032 SHALL cover one-shot: DIV=1, load in=5, start -> count 4,3,2,1,0 on successive edges; done one cycle; expired=1.
REQ-033 SHALL cover periodic: DIV=2, load 3, auto_reload=1, start -> done every 6 clocks, count 3,2,1,3,...; running stays 1.
REQ-034 SHALL cover stop mid-count: load 9, start, stop after 4 ticks -> IDLE, count 5 held, no done; restart -> 5 further ticks to done.
REQ-035 SHALL cover simultaneous start+load in IDLE with in=2 -> RUN with count 2, done 2 ticks later; start with in=0 -> EXPIRED, done pulse.
REQ-036 SHALL cover load during RUN: counting 7 with auto_reload, load 4 -> count unaffected, next reload uses 4.
REQ-037 SHALL cover reset at count 1 one cycle before expiry -> no done, all outputs 0, state IDLE.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared types and default parameters for the down_timer block.
// Imported by the timer top and by its prescaler.
package down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DIV   = 1;

endpackage

// File: rtl/down_timer_tick_gen.sv
// Prescaler for down_timer: emits one tick every DIV enabled clocks.
// With DIV=1 it has no register and ticks on every enabled cycle.
module tick_gen #(
    parameter int DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    generate
        if (DIV == 1) begin : g_passthru
            // Keeps the interface uniform when no prescaler is needed.
            logic w_unused;
            assign w_unused = &{1'b0, clock, reset, clear};
            assign tick     = enable;
        end else begin : g_prescale
            localparam int PW = $clog2(DIV);
            logic [PW-1:0] r_pre;
            logic          w_wrap;

            assign w_wrap = (r_pre == PW'(DIV - 1));
            assign tick   = enable && w_wrap;

            always_ff @(posedge clock) begin
                if (reset || clear) begin
                    r_pre <= '0;
                end else if (enable) begin
                    r_pre <= w_wrap ? '0 : r_pre + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter with one-shot and periodic modes and an optional prescaler.
// State table:
//   ST_IDLE    | stopped, count held, waiting for start
//   ST_RUN     | counting down one step per prescaler tick
//   ST_EXPIRED | reached zero in one-shot mode, waiting for start
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = DEFAULT_DIV
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             done
);

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_count, w_count_n;
    logic [WIDTH-1:0] r_reload, w_reload_n;
    logic             r_done, w_done_n;
    logic             w_tick;
    logic             w_in_run;
    logic [WIDTH-1:0] w_eff_count;

    assign w_in_run = (r_state == ST_RUN);

    // A stop in RUN both suppresses the current tick and zeroes the prescaler.
    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .enable (w_in_run && !stop),
        .clear  (!w_in_run || stop),
        .tick   (w_tick)
    );

    assign w_eff_count = load ? in : r_count;

    always_comb begin
        w_state_n  = r_state;
        w_count_n  = r_count;
        w_reload_n = r_reload;
        w_done_n   = 1'b0;

        if (load) begin
            w_reload_n = in;
        end

        case (r_state)
            ST_RUN: begin
                if (stop) begin
                    w_state_n = ST_IDLE;
                end else if (w_tick) begin
                    if (r_count > WIDTH'(1)) begin
                        w_count_n = r_count - 1'b1;
                    end else begin
                        w_done_n = 1'b1;
                        if (auto_reload && (r_reload != '0)) begin
                            w_count_n = r_reload;
                        end else begin
                            w_count_n = '0;
                            w_state_n = ST_EXPIRED;
                        end
                    end
                end
            end
            default: begin
                if (load) begin
                    w_count_n = in;
                end
                if (start) begin
                    if (w_eff_count != '0) begin
                        w_state_n = ST_RUN;
                    end else begin
                        w_state_n = ST_EXPIRED;
                        w_done_n  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_count  <= w_count_n;
            r_reload <= w_reload_n;
            r_done   <= w_done_n;
        end
    end

    assign count   = r_count;
    assign done    = r_done;
    assign running = (r_state == ST_RUN);
    assign expired = (r_state == ST_EXPIRED);

endmodule
